// File: rtl/keypad_reader.sv
// 4x4 active-low matrix keypad scanner with frame debounce, latched key code
// and a read-only CS_N/IOR_N bus exposing DATA (A0=0) and STATUS (A0=1).
module keypad_reader #(
   parameter int unsigned SCAN_DIV     = 16,
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       CS_N,
   input  logic       IOR_N,
   input  logic       A0,
   output logic [3:0] row_n,
   input  logic [3:0] col_n,
   output logic [7:0] dout,
   output logic       irq
);

   // Codes 0..15 are keys; bit 4 set means "no single key".
   localparam logic [4:0]  CODE_NONE = 5'h10;
   localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
   localparam logic [7:0]  DB_MAX    = 8'(DEBOUNCE_CNT);

   logic [3:0]  col_s1_q, col_s2_q;
   logic [15:0] div_q, div_d;
   logic [1:0]  row_q, row_d;
   logic [3:0]  row_n_q, row_n_d;
   logic [15:0] snap_q, snap_d;
   logic        row_end, frame_end;

   logic [4:0]  frame_code;
   logic [4:0]  ones;
   logic [3:0]  idx;

   logic [4:0]  cand_q, cand_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [4:0]  stable_q, stable_d;
   logic        key_event;

   logic [3:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ovr_q, ovr_d;
   logic        rd_sel_q;
   logic        rd_data_sel, rd_clear;
   logic        key_down;

   // Row scan: each row is driven low for SCAN_DIV clocks; the synced columns
   // are captured on the last clock of that row's slot.
   always_comb begin
      div_d     = div_q;
      row_d     = row_q;
      row_n_d   = row_n_q;
      snap_d    = snap_q;
      row_end   = (div_q == DIV_LAST);
      frame_end = row_end && (row_q == 2'd3);
      if (row_end) begin
         div_d                       = '0;
         row_d                       = row_q + 2'd1;
         row_n_d                     = {row_n_q[2:0], row_n_q[3]};
         snap_d[{row_q, 2'b00} +: 4] = ~col_s2_q;
      end else begin
         div_d = div_q + 16'd1;
      end
   end

   // Frame decode sees the snapshot including the row captured this cycle.
   always_comb begin
      ones = '0;
      idx  = '0;
      for (int i = 0; i < 16; i++) begin
         if (snap_d[i]) begin
            ones = ones + 5'd1;
            idx  = 4'(i);
         end
      end
      frame_code = (ones == 5'd1) ? {1'b0, idx} : CODE_NONE;
   end

   always_comb begin
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      stable_d  = stable_q;
      key_event = 1'b0;
      if (frame_end) begin
         if (frame_code == cand_q) begin
            if (cnt_q != DB_MAX) begin
               cnt_d = cnt_q + 8'd1;
            end
         end else begin
            cand_d = frame_code;
            cnt_d  = 8'd1;
         end
         if ((cnt_d == DB_MAX) && (cand_d != stable_q)) begin
            stable_d  = cand_d;
            key_event = (cand_d != CODE_NONE);
         end
      end
   end

   // A DATA read clears on the first cycle of its strobe only; an event in
   // that same cycle takes priority and leaves a fresh, non-overrun key.
   assign rd_data_sel = ~CS_N & ~IOR_N & ~A0;
   assign rd_clear    = rd_data_sel & ~rd_sel_q;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (key_event) begin
         data_d  = stable_d[3:0];
         valid_d = 1'b1;
         ovr_d   = rd_clear ? 1'b0 : (ovr_q | valid_q);
      end else if (rd_clear) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   assign key_down = (stable_q != CODE_NONE);

   always_comb begin
      dout = 8'h00;
      if (!CS_N && !IOR_N) begin
         dout = A0 ? {5'b0, key_down, ovr_q, valid_q} : {4'h0, data_q};
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         col_s1_q <= 4'hF;
         col_s2_q <= 4'hF;
         div_q    <= '0;
         row_q    <= '0;
         row_n_q  <= 4'b1110;
         snap_q   <= '0;
         cand_q   <= CODE_NONE;
         cnt_q    <= '0;
         stable_q <= CODE_NONE;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         rd_sel_q <= 1'b0;
      end else begin
         col_s1_q <= col_n;
         col_s2_q <= col_s1_q;
         div_q    <= div_d;
         row_q    <= row_d;
         row_n_q  <= row_n_d;
         snap_q   <= snap_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
         rd_sel_q <= rd_data_sel;
      end
   end

   assign row_n = row_n_q;
   assign irq   = valid_q;

endmodule

// File: tb/tb_keypad_reader.sv
// Bench for keypad_reader: a keypad matrix model, a frame-level reference
// model checked every cycle, directed scenarios and a randomized phase.
module tb_keypad_reader;

   localparam int SD   = 4;
   localparam int DB   = 3;
   localparam int NONE = -1;

   logic       clk_in;
   logic       rst;
   logic       CS_N, IOR_N, A0;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [7:0] dout;
   logic       irq;
   logic [15:0] pressed;

   int n_checks = 0;
   int n_err    = 0;
   logic [7:0] exp_q[$];

   keypad_reader #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
      .clk_in(clk_in), .rst(rst), .CS_N(CS_N), .IOR_N(IOR_N), .A0(A0),
      .row_n(row_n), .col_n(col_n), .dout(dout), .irq(irq)
   );

   // ---------------- clock ----------------
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   // Physical keypad: a pressed key shorts its column to its row line.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         col_n[c] = ~((pressed[c] & ~row_n[0]) | (pressed[4 + c] & ~row_n[1]) |
                      (pressed[8 + c] & ~row_n[2]) | (pressed[12 + c] & ~row_n[3]));
      end
   end

   // ---------------- reference model ----------------
   int         m_t;
   logic [3:0] m_h1, m_h2;
   logic [15:0] m_snap;
   int         m_fq[$];
   int         m_stable;
   logic [3:0] m_data;
   bit         m_valid, m_ovr, m_sel_prev, m_ready = 0;

   function automatic logic [3:0] model_cols(int row);
      logic [3:0] c;
      for (int k = 0; k < 4; k++) c[k] = ~pressed[row * 4 + k];
      return c;
   endfunction

   always @(posedge clk_in) begin : model
      int row, code;
      logic [3:0] used;
      bit sel, clr, ev, same;
      if (rst) begin
         m_t = 0; m_h1 = 4'hF; m_h2 = 4'hF; m_snap = '0;
         m_fq.delete(); m_stable = NONE; m_data = '0;
         m_valid = 0; m_ovr = 0; m_sel_prev = 0; m_ready = 1;
      end else begin
         row  = (m_t / SD) % 4;
         used = m_h2; m_h2 = m_h1; m_h1 = model_cols(row);
         ev = 0; code = NONE;
         if ((m_t % SD) == SD - 1) begin
            for (int k = 0; k < 4; k++) m_snap[row * 4 + k] = ~used[k];
            if (row == 3) begin
               if ($countones(m_snap) == 1)
                  for (int b = 0; b < 16; b++) if (m_snap[b]) code = b;
               m_fq.push_back(code);
               if (m_fq.size() > DB) void'(m_fq.pop_front());
               same = (m_fq.size() == DB);
               foreach (m_fq[i]) if (m_fq[i] != code) same = 0;
               if (same && code != m_stable) begin
                  m_stable = code;
                  ev = (code != NONE);
               end
            end
         end
         sel = !CS_N && !IOR_N && !A0;
         clr = sel && !m_sel_prev;
         m_sel_prev = sel;
         if (ev) begin
            m_data = 4'(code);
            m_ovr = clr ? 1'b0 : (m_ovr | m_valid);
            m_valid = 1;
         end else if (clr) begin
            m_valid = 0; m_ovr = 0;
         end
         m_t++;
      end
   end

   function automatic logic [3:0] exp_row_n();
      logic [3:0] r;
      r = 4'hF;
      r[(m_t / SD) % 4] = 1'b0;
      return r;
   endfunction

   function automatic logic [7:0] exp_dout();
      if (!CS_N && !IOR_N)
         return A0 ? {5'b0, (m_stable != NONE), m_ovr, m_valid} : {4'h0, m_data};
      return 8'h00;
   endfunction

   function automatic bit about_to_accept(int code);
      int n;
      n = m_fq.size();
      if (m_stable == code || n < DB - 1) return 0;
      for (int i = n - (DB - 1); i < n; i++) if (m_fq[i] != code) return 0;
      return (m_t % (4 * SD)) == 4 * SD - 1;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) begin
      if (m_ready) begin
         check("row_n", {4'h0, row_n}, {4'h0, exp_row_n()});
         check("irq", {7'h0, irq}, {7'h0, m_valid});
         check("dout", dout, exp_dout());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_in);
      #2;
   endtask

   task automatic bus_idle();
      CS_N = 1'b1; IOR_N = 1'b1; A0 = 1'b0;
   endtask

   // Zero-time read between edges: observes dout without a clocked strobe.
   task automatic peek(logic a0, string name, logic [7:0] exp);
      CS_N = 1'b0; IOR_N = 1'b0; A0 = a0;
      #1;
      check(name, dout, exp);
      bus_idle();
   endtask

   task automatic read_data(int len, string name);
      logic [7:0] exp;
      exp = exp_q.pop_front();
      CS_N = 1'b0; IOR_N = 1'b0; A0 = 1'b0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk_in);
         check(name, dout, exp);
         step();
      end
      bus_idle();
   endtask

   task automatic wait_irq(int max_cyc, string name, output int n);
      n = 0;
      while (n < max_cyc) begin
         step();
         n++;
         @(negedge clk_in);
         if (irq) break;
      end
      check(name, {7'h0, irq}, 8'h01);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, hold;
      bit hit;
      pressed = '0; rst = 1'b1; bus_idle();

      // Reset and idle scanning
      repeat (3) step();
      peek(1'b0, "reset_data", 8'h00);
      peek(1'b1, "reset_status", 8'h00);
      check("reset_row_n", {4'h0, row_n}, 8'h0E);
      check("reset_irq", {7'h0, irq}, 8'h00);
      rst = 1'b0;
      repeat (200) step();
      check("idle_irq", {7'h0, irq}, 8'h00);

      // Single press: row2/col1 = key 9
      pressed[9] = 1'b1;
      wait_irq(2 + (DB + 1) * 4 * SD, "press9_latency", n);
      step();
      peek(1'b1, "press9_status_before", 8'h05);
      exp_q.push_back(8'h09);
      read_data(5, "press9_data");
      peek(1'b1, "press9_status_after", 8'h04);
      repeat (100 - n - 7) step();
      pressed = '0;
      repeat (80) step();
      peek(1'b1, "release9_status", 8'h00);

      // Bounce on key 3, then settle
      for (int i = 0; i < 10; i++) begin
         pressed[3] = ~pressed[3];
         repeat (20) step();
      end
      pressed[3] = 1'b1;
      repeat (80) step();
      peek(1'b1, "bounce_status", 8'h05);
      exp_q.push_back(8'h03);
      read_data(1, "bounce_data");
      pressed = '0;
      repeat (80) step();

      // Overrun: key 5 then key 14 without reading
      pressed[5] = 1'b1;
      wait_irq(2 + (DB + 1) * 4 * SD, "key5_latency", n);
      step();
      pressed = '0;
      repeat (80) step();
      pressed[14] = 1'b1;
      repeat (80) step();
      peek(1'b1, "overrun_status", 8'h07);
      exp_q.push_back(8'h0E);
      read_data(1, "overrun_data");
      peek(1'b1, "overrun_status_after", 8'h04);
      pressed = '0;
      repeat (80) step();

      // Ghosting: keys 0 and 5 together, then release 5
      pressed[0] = 1'b1; pressed[5] = 1'b1;
      repeat (80) step();
      peek(1'b1, "ghost_status", 8'h00);
      pressed[5] = 1'b0;
      wait_irq(2 + (DB + 1) * 4 * SD, "ghost_release_latency", n);
      step();
      peek(1'b1, "ghost_release_status", 8'h05);
      exp_q.push_back(8'h00);
      read_data(1, "ghost_release_data");
      pressed = '0;
      repeat (80) step();

      // Collision: DATA-read strobe rises on the event cycle, VALID already set
      pressed[2] = 1'b1;
      wait_irq(2 + (DB + 1) * 4 * SD, "key2_latency", n);
      step();
      pressed = '0;
      repeat (80) step();
      peek(1'b1, "pending_status", 8'h01);
      pressed[7] = 1'b1;
      hit = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (about_to_accept(7)) begin
            hit = 1;
            break;
         end
      end
      check("collision_align", {7'h0, hit}, 8'h01);
      CS_N = 1'b0; IOR_N = 1'b0; A0 = 1'b0;
      step();
      @(negedge clk_in);
      check("collision_data", dout, 8'h07);
      step();
      bus_idle();
      peek(1'b1, "collision_status", 8'h05);
      pressed = '0;
      repeat (80) step();

      // Reset in the middle of debouncing key 11
      pressed[11] = 1'b1;
      repeat (24) step();
      rst = 1'b1;
      step();
      peek(1'b1, "midreset_status", 8'h00);
      peek(1'b0, "midreset_data", 8'h00);
      check("midreset_row_n", {4'h0, row_n}, 8'h0E);
      rst = 1'b0;
      wait_irq(100, "refill_irq", n);
      check("refill_latency", 8'(n), 8'd48);
      step();
      peek(1'b1, "refill_status", 8'h05);
      exp_q.push_back(8'h0B);
      read_data(1, "refill_data");
      pressed = '0;
      repeat (80) step();

      // Randomized phase: random keys, holds, bus traffic and occasional resets
      for (int blk = 0; blk < 40; blk++) begin
         case ($urandom_range(0, 3))
            0: pressed = '0;
            1, 2: begin
               pressed = '0;
               pressed[$urandom_range(0, 15)] = 1'b1;
            end
            default: begin
               pressed = '0;
               pressed[$urandom_range(0, 15)] = 1'b1;
               pressed[$urandom_range(0, 15)] = 1'b1;
            end
         endcase
         hold = $urandom_range(10, 120);
         for (int c = 0; c < hold; c++) begin
            case ($urandom_range(0, 9))
               0, 1: begin
                  CS_N = 1'b0; IOR_N = 1'b0; A0 = 1'($urandom_range(0, 1));
               end
               2: begin
                  CS_N = 1'b0; IOR_N = 1'b1; A0 = 1'b0;
               end
               default: bus_idle();
            endcase
            rst = ($urandom_range(0, 999) == 0);
            step();
         end
         bus_idle();
         rst = 1'b0;
      end
      pressed = '0;
      repeat (20) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_reader.md
Name: keypad_reader

Overview:
- Read-side IO-mapped peripheral: scans a 4x4 active-low matrix keypad, debounces it and latches the code of each new keypress.
- The CPU reads the key code and status through the chip-select/read-strobe bus (CS_N, IOR_N, A0, dout).
- It is the counterpart of the write-only output devices on the same bus.
- irq flags a pending key to the interrupt logic.

Parameters:
- SCAN_DIV, 16, clocks each row is driven low; legal range 2..65535.
- DEBOUNCE_CNT, 4, consecutive identical frames required before a key state is accepted; legal range 1..255.

Ports:
- clk_in  input  1  system clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- CS_N  input  1  chip select, active-low.
- IOR_N  input  1  read strobe, active-low.
- A0  input  1  register select: 0 = DATA, 1 = STATUS.
- row_n  output  4  keypad row drive, active-low, one-hot-low.
- col_n  input  4  keypad column sense, active-low, asynchronous.
- dout  output  8  read data.
- irq  output  1  equals VALID.

Behaviour:
- Reset values (sync, rst=1 at clk_in edge):
  - row_n=4'b1110; row index=0; divider=0; frame snapshot=0.
  - candidate=NONE; debounce count=0; stable=NONE.
  - DATA=8'h00; VALID=0; OVR=0; irq=0.
  - Reset mid-scan or mid-debounce discards all partial state.
- Input sync: col_n passes through a 2-flop synchronizer; the synchronized value is used everywhere.
- Scan:
  - Divider counts 0..SCAN_DIV-1 per row.
  - On divider==SCAN_DIV-1: store inverted synced columns into snapshot bits [row*4+3:row*4], advance row (3 wraps to 0), rotate row_n (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - Completing row 3 ends a frame.
- Frame decode (at frame end):
  - Exactly one snapshot bit set: frame code = that bit index (row*4+col, 0..15).
  - Zero bits or more than one bit set (ghosting/multi-press): frame code = NONE.
- Debounce:
  - If frame code == candidate: count saturates at DEBOUNCE_CNT. Otherwise candidate=frame code, count=1.
  - When count reaches DEBOUNCE_CNT and candidate != stable: stable=candidate.
  - A key event fires if the new stable value is not NONE. This covers NONE->key and key->different key.
  - Release (key->NONE) updates stable but fires no event.
  - DEBOUNCE_CNT=1 accepts on the first frame.
- Key event (one clk_in cycle):
  - DATA={4'h0,code}.
  - If VALID was already 1, OVR=1.
  - VALID=1.
- Read:
  - dout is combinational.
  - CS_N=0, IOR_N=0, A0=0: DATA.
  - CS_N=0, IOR_N=0, A0=1: {5'b0, KEY_DOWN, OVR, VALID}, where KEY_DOWN = (stable != NONE).
  - Otherwise dout=8'h00.
- Read-clear:
  - A registered copy of the DATA-read select (CS_N=0 & IOR_N=0 & A0=0) is kept.
  - The first cycle that select is high while its registered copy is low clears VALID and OVR.
  - A long strobe clears only once. STATUS reads never clear.
  - If a key event and a clear occur in the same cycle, the event wins: DATA=new code, VALID=1, OVR=0.
- Latency: key stable at pins -> VALID=1 within 2 + (DEBOUNCE_CNT+1)*4*SCAN_DIV clocks.

Test Plan:
(Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=3; frame = 16 clocks.)
1. Reset: assert rst 3 clocks, no keys -> row_n=1110, dout=00 on both addresses, irq=0. Run 200 clocks -> row_n cycles 1110/1101/1011/0111, 4 clocks each; irq stays 0.
2. Single press: model key row2/col1 (col_n[1]=0 while row_n[2]=0), hold 100 clocks -> irq=1 within 2+4*16 clocks. DATA read returns 8'h09. STATUS returns 8'h05 before the read and 8'h04 after. A 5-cycle strobe clears once.
3. Bounce: toggle key 3 (row0/col3) every 20 clocks for 200 clocks, then hold 80 clocks -> exactly one event; DATA=8'h03; OVR=0.
4. Overrun: press key 5, release, press key 14 without reading -> STATUS=8'h07 while 14 is held; DATA=8'h0E. After the DATA read, STATUS=8'h04.
5. Ghost/multi: hold keys 0 and 5 together -> no event, KEY_DOWN=0. Release key 5 -> event with DATA=8'h00.
6. Collision and reset: align the DATA-read strobe rising edge with the event cycle -> VALID=1, OVR=0, new code. Assert rst mid-debounce -> all state returns to reset values; no event follows until 3 fresh frames complete.
